// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - shared types and constants for the memory request sequencer
package mem_seq_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 10;
    localparam int RSP_DEPTH  = 4;
    localparam int LOCK_QUAL  = 4;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        CLEAR     = 2'd1,
        RUN       = 2'd2
    } seq_state_e;

endpackage

// File: rtl/mem_seq_rsp_fifo.sv
// rtl/mem_seq_rsp_fifo.sv - small response FIFO holding read data until the consumer takes it
module mem_seq_rsp_fifo
    import mem_seq_pkg::*;
#(
    parameter  int W     = DEF_DATA_W,
    parameter  int DEPTH = RSP_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/mem_req_sequencer.sv
// rtl/mem_req_sequencer.sv - SRAM request sequencer: lock qualification, zero-fill, then credited request traffic
module mem_req_sequencer
    import mem_seq_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INIT_EN = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              pll_lock,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              mem_chip_en,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              init_done,
    output logic              lock_lost
);

    localparam int                CNT_W     = $clog2(RSP_DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(RSP_DEPTH);
    localparam int                LQ_W      = $clog2(LOCK_QUAL);
    localparam logic [LQ_W-1:0]   LOCK_LAST = LQ_W'(LOCK_QUAL - 1);

    seq_state_e        state_q;
    logic              lock_s1_q;
    logic              lock_s2_q;
    logic [LQ_W-1:0]   lock_cnt_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic              mem_chip_en_q;
    logic              mem_wr_en_q;
    logic              mem_rd_en_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wr_data_q;
    logic              rd_cap_q;
    logic              init_done_q;
    logic              lock_lost_q;

    logic              req_fire;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  used;

    // A read holds its credit from accept, through the macro and capture stages, until it is popped.
    assign used      = fifo_count + CNT_W'(mem_rd_en_q) + CNT_W'(rd_cap_q);
    assign req_ready = (state_q == RUN) && (used < DEPTH_C) && !fifo_full;
    assign req_fire  = req_valid && req_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= WAIT_LOCK;
            lock_s1_q     <= 1'b0;
            lock_s2_q     <= 1'b0;
            lock_cnt_q    <= '0;
            clr_addr_q    <= '0;
            mem_chip_en_q <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            rd_cap_q      <= 1'b0;
            init_done_q   <= 1'b0;
            lock_lost_q   <= 1'b0;
        end else begin
            lock_s1_q     <= pll_lock;
            lock_s2_q     <= lock_s1_q;
            mem_chip_en_q <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            rd_cap_q      <= mem_rd_en_q;
            if ((state_q != WAIT_LOCK) && !lock_s2_q) begin
                lock_lost_q <= 1'b1;
            end
            case (state_q)
                WAIT_LOCK: begin
                    if (!lock_s2_q) begin
                        lock_cnt_q <= '0;
                    end else if (lock_cnt_q == LOCK_LAST) begin
                        lock_cnt_q  <= '0;
                        state_q     <= (INIT_EN != 0) ? CLEAR : RUN;
                        init_done_q <= (INIT_EN == 0);
                    end else begin
                        lock_cnt_q <= lock_cnt_q + 1'b1;
                    end
                end
                CLEAR: begin
                    mem_chip_en_q <= 1'b1;
                    mem_wr_en_q   <= 1'b1;
                    mem_addr_q    <= clr_addr_q;
                    mem_wr_data_q <= '0;
                    clr_addr_q    <= clr_addr_q + 1'b1;
                    if (clr_addr_q == '1) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (req_fire) begin
                        mem_chip_en_q <= 1'b1;
                        mem_wr_en_q   <= req_write;
                        mem_rd_en_q   <= !req_write;
                        mem_addr_q    <= req_addr;
                        if (req_write) begin
                            mem_wr_data_q <= req_wdata;
                        end
                    end
                end
                default: state_q <= WAIT_LOCK;
            endcase
        end
    end

    mem_seq_rsp_fifo #(
        .W     (DATA_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clock),
        .rst_n     (reset_n),
        .push      (rd_cap_q),
        .push_data (mem_rd_data),
        .pop       (rsp_ready),
        .pop_data  (rsp_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rsp_valid   = !fifo_empty;
    assign mem_chip_en = mem_chip_en_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_data = mem_wr_data_q;
    assign init_done   = init_done_q;
    assign lock_lost   = lock_lost_q;

endmodule

// File: tb/tb_mem_req_sequencer.sv
// tb/tb_mem_req_sequencer.sv - self-checking bench for mem_req_sequencer with an SRAM model and scoreboard
module tb_mem_req_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        pll_lock;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [9:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        mem_chip_en, mem_wr_en, mem_rd_en;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wr_data;
    logic [15:0] mem_rd_data;
    logic        init_done, lock_lost;

    logic        d0_req_ready, d0_rsp_valid, d0_chip_en, d0_wr_en, d0_rd_en;
    logic [15:0] d0_rsp_data, d0_wr_data;
    logic [9:0]  d0_addr;
    logic        d0_init_done, d0_lock_lost;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] sram [1024];
    logic [15:0] ref_mem [1024];
    logic [15:0] exp_q [$];
    int          outstanding;
    logic [9:0]  exp_addr;
    logic [15:0] exp_wd;
    logic        hold_prev;
    logic [15:0] prev_data;
    logic        d0_wr_seen = 1'b0;

    always #5 clock = ~clock;

    mem_req_sequencer dut (
        .clock(clock), .reset_n(reset_n), .pll_lock(pll_lock),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mem_chip_en(mem_chip_en), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .init_done(init_done), .lock_lost(lock_lost)
    );

    mem_req_sequencer #(.INIT_EN(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .pll_lock(pll_lock),
        .req_valid(1'b0), .req_ready(d0_req_ready), .req_write(1'b0),
        .req_addr(10'h0), .req_wdata(16'h0),
        .rsp_valid(d0_rsp_valid), .rsp_ready(1'b0), .rsp_data(d0_rsp_data),
        .mem_chip_en(d0_chip_en), .mem_wr_en(d0_wr_en), .mem_rd_en(d0_rd_en),
        .mem_addr(d0_addr), .mem_wr_data(d0_wr_data), .mem_rd_data(16'h0),
        .init_done(d0_init_done), .lock_lost(d0_lock_lost)
    );

    // SRAM macro: read data appears one clock after the rd_en cycle.
    always @(posedge clock) begin
        if (mem_chip_en && mem_wr_en) sram[mem_addr] <= mem_wr_data;
        if (mem_chip_en && mem_rd_en) mem_rd_data <= sram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        if (d0_wr_en) d0_wr_seen = 1'b1;
    endtask

    // One RUN-state cycle against the reference: credits, response order/stability, pin timing.
    task automatic tick();
        logic fire, pop, w;
        if (hold_prev) chk("rsp_stable", 32'(rsp_data), 32'(prev_data));
        chk("req_ready", 32'(req_ready), 32'(outstanding < 4));
        chk("rsp_spurious", 32'(rsp_valid && (exp_q.size() == 0)), 32'(0));
        fire = req_valid && req_ready;
        pop  = rsp_valid && rsp_ready;
        w    = req_write;
        if (pop && exp_q.size() > 0) begin
            chk("rsp_data", 32'(rsp_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            outstanding--;
        end
        if (fire) begin
            if (w) begin
                ref_mem[req_addr] = req_wdata;
                exp_wd = req_wdata;
            end else begin
                exp_q.push_back(ref_mem[req_addr]);
                outstanding++;
            end
            exp_addr = req_addr;
        end
        hold_prev = rsp_valid && !rsp_ready;
        prev_data = rsp_data;
        step();
        chk("mem_en", 32'({mem_chip_en, mem_wr_en, mem_rd_en}), 32'({fire, fire && w, fire && !w}));
        chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        chk("mem_wdata", 32'(mem_wr_data), 32'(exp_wd));
    endtask

    task automatic drain();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (8) tick();
        rsp_ready = 1'b0;
        chk("drain_left", 32'(exp_q.size()), 32'(0));
        chk("drain_valid", 32'(rsp_valid), 32'(0));
    endtask

    task automatic rand_traffic(input int n);
        repeat (n) begin
            req_valid = 1'($urandom_range(0, 1));
            req_write = ($urandom_range(0, 2) == 0);
            req_addr  = 10'h20 + 10'($urandom_range(0, 7));
            req_wdata = 16'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
    endtask

    task automatic run_clear(output int nwr, output int bad);
        nwr = 0;
        bad = 0;
        while (mem_wr_en && nwr < 1100) begin
            if (mem_addr !== 10'(nwr) || mem_wr_data !== 16'h0 || mem_chip_en !== 1'b1 || mem_rd_en !== 1'b0) bad++;
            if (nwr < 1023 && (init_done !== 1'b0 || req_ready !== 1'b0)) bad++;
            nwr++;
            step();
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h0;
        exp_q.delete();
        outstanding = 0;
        exp_addr    = 10'h3FF;
        exp_wd      = 16'h0;
        hold_prev   = 1'b0;
    endtask

    initial begin
        int k, nwr, bad, lat, acc;
        logic r;
        model_reset();
        reset_n = 1'b0; pll_lock = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 10'h0; req_wdata = 16'h0; rsp_ready = 1'b0;
        repeat (3) step();
        chk("rst_ready", 32'(req_ready), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_mem_en", 32'({mem_chip_en, mem_wr_en, mem_rd_en}), 32'(0));
        chk("rst_addr", 32'(mem_addr), 32'(0));
        chk("rst_init_done", 32'(init_done), 32'(0));
        chk("rst_lock_lost", 32'(lock_lost), 32'(0));

        reset_n = 1'b1;
        step();
        chk("release_mem_en", 32'({mem_chip_en, mem_wr_en, mem_rd_en}), 32'(0));
        chk("wait_ready", 32'(req_ready), 32'(0));

        // Lock glitch: 3 high, 1 low, then steady high.
        pll_lock = 1'b1;
        repeat (3) step();
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        k = 0;
        while (!mem_wr_en && k < 20) begin
            step();
            k++;
            chk("glitch_init_done", 32'(init_done), 32'(0));
        end
        chk("lock_latency", 32'(k), 32'(7));
        chk("noinit_run", 32'(d0_init_done), 32'(1));
        chk("clear_first_addr", 32'(mem_addr), 32'(0));

        run_clear(nwr, bad);
        chk("clear_count", 32'(nwr), 32'(1024));
        chk("clear_bad", 32'(bad), 32'(0));
        chk("clear_init_done", 32'(init_done), 32'(1));
        chk("run_ready", 32'(req_ready), 32'(1));

        // Write then read the same address back-to-back.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h3A5; req_wdata = 16'hBEEF;
        tick();
        req_write = 1'b0;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk("rd_latency", 32'(lat), 32'(3));
        chk("rd_after_wr", 32'(rsp_data), 32'(16'hBEEF));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Backpressure: credits cap outstanding reads at four.
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h10 + 10'(i); req_wdata = 16'($urandom);
            tick();
        end
        req_write = 1'b0;
        req_addr  = 10'h10;
        acc = 0;
        repeat (12) begin
            r = req_ready;
            tick();
            if (r) begin acc++; req_addr = req_addr + 10'd1; end
        end
        chk("bp_accepts", 32'(acc), 32'(4));
        chk("bp_ready_low", 32'(req_ready), 32'(0));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        acc = 0;
        repeat (10) begin
            r = req_ready;
            tick();
            if (r) begin acc++; req_addr = req_addr + 10'd1; end
        end
        chk("bp_reaccept", 32'(acc), 32'(1));
        drain();

        rand_traffic(400);
        drain();

        // Lock loss in RUN: sticky flag, traffic continues.
        chk("pre_lock_lost", 32'(lock_lost), 32'(0));
        pll_lock = 1'b0;
        rand_traffic(100);
        drain();
        chk("lock_lost", 32'(lock_lost), 32'(1));
        chk("lost_init_done", 32'(init_done), 32'(1));
        pll_lock = 1'b1;

        // Reset in RUN with a full FIFO abandons its contents.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h20; rsp_ready = 1'b0;
        repeat (8) tick();
        chk("fifo_loaded", 32'(rsp_valid), 32'(1));
        req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_run_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_run_lock_lost", 32'(lock_lost), 32'(0));
        chk("rst_run_init_done", 32'(init_done), 32'(0));
        model_reset();
        repeat (2) step();
        reset_n = 1'b1;
        step();
        chk("release2_mem_en", 32'({mem_chip_en, mem_wr_en, mem_rd_en}), 32'(0));

        // Reset mid-CLEAR at 0x100, then CLEAR restarts at 0.
        k = 0;
        while (!(mem_wr_en && mem_addr == 10'h100) && k < 1300) begin
            step();
            k++;
        end
        chk("reach_0x100", 32'(mem_addr), 32'(10'h100));
        reset_n = 1'b0;
        #1;
        chk("midclr_mem_en", 32'({mem_chip_en, mem_wr_en, mem_rd_en}), 32'(0));
        chk("midclr_init_done", 32'(init_done), 32'(0));
        repeat (2) step();
        reset_n = 1'b1;
        k = 0;
        while (!mem_wr_en && k < 20) begin
            step();
            k++;
        end
        chk("relock_latency", 32'(k), 32'(7));
        chk("clear_restart_addr", 32'(mem_addr), 32'(0));
        run_clear(nwr, bad);
        chk("clear2_count", 32'(nwr), 32'(1024));
        chk("clear2_bad", 32'(bad), 32'(0));

        // Previously written address reads back as zero after the second fill.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h3A5;
        tick();
        drain();
        rand_traffic(100);
        drain();

        chk("noinit_no_writes", 32'(d0_wr_seen), 32'(0));
        chk("noinit_init_done", 32'(d0_init_done), 32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_req_sequencer.md
MEM_REQ_SEQUENCER -- requirements
Module: mem_req_sequencer

Interface
REQ-001 Parameter DATA_W, 16, data width of the SRAM macro word.
REQ-002 Parameter ADDR_W, 10, address width; the macro depth is 2**ADDR_W.
REQ-003 Parameter INIT_EN, 1, when 1 the block zero-fills the memory after lock; when 0 it skips the fill.
REQ-004 Ports, one per line:
  clock  in  1  sole clock; all flops rise-edge.
  reset_n  in  1  asynchronous active-low reset.
  pll_lock  in  1  PLL LOCK, asynchronous to clock.
  req_valid  in  1  request offered.
  req_ready  out  1  request accepted when valid&ready.
  req_write  in  1  1=write, 0=read.
  req_addr  in  ADDR_W  request address.
  req_wdata  in  DATA_W  write data.
  rsp_valid  out  1  read data available.
  rsp_ready  in  1  consumer takes rsp_data when valid&ready.
  rsp_data  out  DATA_W  read data, in request order.
  mem_chip_en, mem_wr_en, mem_rd_en  out  1 each  macro controls, registered.
  mem_addr  out  ADDR_W  macro address, registered.
  mem_wr_data  out  DATA_W  macro write data, registered.
  mem_rd_data  in  DATA_W  macro read data, valid one clock after the mem_rd_en cycle.
  init_done  out  1  high once the RUN state is entered.
  lock_lost  out  1  sticky; pll_lock fell while in CLEAR or RUN.

Function
REQ-005 pll_lock SHALL pass a 2-flop synchronizer before use.
REQ-006 FSM states SHALL be WAIT_LOCK, CLEAR, and RUN; reset enters WAIT_LOCK.
REQ-007 WAIT_LOCK SHALL exit after the synchronized lock is high for 4 consecutive cycles, going to CLEAR if INIT_EN=1 and to RUN otherwise; a low sample restarts the count.
REQ-008 CLEAR SHALL issue one write per cycle: chip_en=1, wr_en=1, rd_en=0, wr_data=0, addr 0 through 2**ADDR_W-1 ascending, then enter RUN the cycle after the last address.
REQ-009 req_ready SHALL be 0 outside RUN.
REQ-010 In RUN, req_ready SHALL be 1 exactly when credits>0, where credits = 4 - (FIFO occupancy + reads in flight); req_ready SHALL NOT depend on req_valid or req_write.
REQ-011 An accepted request in cycle N SHALL drive the mem_* pins in cycle N+1. A write drives chip_en=1 and wr_en=1. A read drives chip_en=1 and rd_en=1. With no accept, all three enables are 0 and addr and wr_data hold their values.
REQ-012 A read's mem_rd_data SHALL be captured into the 4-deep response FIFO at the end of cycle N+2; rsp_valid rises in N+3 at the earliest.
REQ-013 Writes SHALL consume no credit; reads SHALL consume one credit from accept until popped.
REQ-014 A simultaneous FIFO push and pop SHALL leave occupancy unchanged; FIFO overflow is structurally impossible by REQ-010.
REQ-015 Memory operations SHALL be issued in acceptance order, so a read after a write to the same address returns the new data.
REQ-016 rsp_data SHALL be stable while rsp_valid=1 and rsp_ready=0.
REQ-017 A pll_lock drop in CLEAR or RUN SHALL set lock_lost, which clears only on reset; the FSM SHALL not change state.
REQ-018 init_done SHALL be 1 in RUN and 0 in the other states.

Reset
REQ-019 reset_n low SHALL asynchronously clear every flop: state=WAIT_LOCK, all outputs 0, FIFO empty, credits=4, sync chain 0.
REQ-020 Reset during CLEAR or RUN SHALL abandon all in-flight reads and FIFO contents; after release the lock qualification and CLEAR restart from scratch.
REQ-021 Reset release SHALL be synchronized externally; no mem_* enable may be high in the first cycle after release.

Structure
REQ-022 Package mem_seq_pkg SHALL hold the state enum, the DATA_W/ADDR_W defaults, RSP_DEPTH=4, and LOCK_QUAL=4.
REQ-023 The response FIFO SHALL be the sub-module mem_seq_rsp_fifo (depth RSP_DEPTH; push, pop, full, empty, count).

Verification
REQ-024 Lock glitch: pll_lock high 3 cycles, low 1, then high → CLEAR starts 4 synchronized cycles after the re-rise (plus 2 sync cycles); init_done=0 throughout.
REQ-025 Clear: INIT_EN=1 → exactly 1024 writes of 0x0000 to addr 0x000..0x3FF, then init_done=1; INIT_EN=0 → no mem writes and RUN immediately.
REQ-026 Write then read: write 0x3A5 ← 0xBEEF, then read 0x3A5 back-to-back → rsp_data=0xBEEF, rsp_valid 3 cycles after the read accept.
REQ-027 Backpressure: rsp_ready=0, 6 reads offered → 4 accepted, req_ready=0 after that; popping 1 re-enables exactly 1 accept; data order preserved.
REQ-028 Lock loss and reset: drop pll_lock in RUN → lock_lost=1 and traffic continues. Assert reset_n mid-CLEAR at addr 0x100 → mem enables go 0 immediately, and after re-lock CLEAR restarts at 0x000.
